// File: rtl/mem_arbiter.sv
// Arbiter for the shared instruction/data memory port.
// Only one transaction is in flight at a time, and the memory has a fixed
// read latency. Data accesses have priority over fetches. A streak limiter
// forces a fetch grant after MAX_DSTREAK consecutive data grants made while
// a fetch was waiting.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no transaction outstanding; any pending request may be granted
// ST_BUSY | one transaction outstanding; cnt counts down to its response
module mem_arbiter #(
  parameter int LAT         = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] LAT_C = 4'(LAT);
  localparam logic [3:0] MAX_C = 4'(MAX_DSTREAK);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     state, state_n;
  logic       owner, owner_n;        // 0 fetch, 1 data
  logic       owner_we, owner_we_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] dstreak, dstreak_n;
  logic       resp, window, win_d, win_i;

  // State register; reset drops any outstanding transaction and its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      owner_we <= 1'b0;
      cnt      <= '0;
      dstreak  <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      owner_we <= owner_we_n;
      cnt      <= cnt_n;
      dstreak  <= dstreak_n;
    end
  end

  // Arbitration, next-state logic and the memory/response output muxes.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    owner_we_n = owner_we;
    cnt_n      = cnt;
    dstreak_n  = dstreak;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    if_rdata   = '0;
    d_rdata    = '0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_size     = 2'b00;
    m_addr     = '0;
    m_wdata    = '0;

    // The response cycle doubles as the next arbitration window, so a
    // back-to-back request costs no idle cycle. Everything is held quiet
    // while rst is asserted.
    resp   = !rst && (state == ST_BUSY) && (cnt == 4'd1);
    window = !rst && ((state == ST_IDLE) || resp);
    win_d  = window && d_req && !(if_req && (dstreak == MAX_C));
    win_i  = window && if_req && !win_d;

    if (win_d || win_i) begin
      state_n    = ST_BUSY;
      owner_n    = win_d;
      owner_we_n = win_d && d_we;
      cnt_n      = LAT_C;
    end else if (resp) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (state == ST_BUSY) begin
      cnt_n = cnt - 4'd1;
    end

    // The streak only counts data grants made while a fetch is waiting.
    if (!if_req || win_i) begin
      dstreak_n = '0;
    end else if (win_d && (dstreak != MAX_C)) begin
      dstreak_n = dstreak + 4'd1;
    end

    if_gnt = win_i;
    d_gnt  = win_d;
    m_en   = win_d || win_i;
    if (win_d) begin
      m_we    = d_we;
      m_size  = d_size;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (win_i) begin
      m_size = 2'b10;
      m_addr = if_addr;
    end

    if_rvalid = resp && !owner;
    d_rvalid  = resp && owner;
    if (if_rvalid) begin
      if_rdata = m_rdata;
    end
    if (d_rvalid && !owner_we) begin
      d_rdata = m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: u0 uses LAT=2/MAX_DSTREAK=4, u1 uses LAT=1/MAX_DSTREAK=1.
// Both instances share the same input stimulus.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;

  logic [1:0]       if_gnt, d_gnt, if_rvalid, d_rvalid, m_en, m_we;
  logic [1:0][1:0]  m_size;
  logic [1:0][31:0] if_rdata, d_rdata, m_addr, m_wdata;

  mem_arbiter #(.LAT(2), .MAX_DSTREAK(4)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]),
    .d_rdata(d_rdata[0]), .m_en(m_en[0]), .m_we(m_we[0]),
    .m_size(m_size[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata)
  );

  mem_arbiter #(.LAT(1), .MAX_DSTREAK(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]),
    .d_rdata(d_rdata[1]), .m_en(m_en[1]), .m_we(m_we[1]),
    .m_size(m_size[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [135:0] pk(input logic ig, dg, iv, dv, men, mwe,
                                      input logic [1:0] msz,
                                      input logic [31:0] maddr, mwd, ird, drd);
    return {ig, dg, iv, dv, men, mwe, msz, maddr, mwd, ird, drd};
  endfunction

  function automatic logic [135:0] outs(input int k);
    return pk(if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], m_en[k], m_we[k],
              m_size[k], m_addr[k], m_wdata[k], if_rdata[k], d_rdata[k]);
  endfunction

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [1:0]  dsz;
    logic [31:0] da, dwd, mrd;
    logic [135:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, ir, input logic [31:0] ia, input logic dr, dwe,
                     input logic [1:0] dsz, input logic [31:0] da, dwd, mrd,
                     input logic ig, dg, iv, dv, men, mwe, input logic [1:0] msz,
                     input logic [31:0] maddr, mwd, ird, drd);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dsz = dsz;
    v.da = da; v.dwd = dwd; v.mrd = mrd;
    v.exp = pk(ig, dg, iv, dv, men, mwe, msz, maddr, mwd, ird, drd);
    vecs.push_back(v);
  endtask

  // Reference model: a transaction is remembered by the cycle number at
  // which its response is due, not by a countdown.
  int lat_k[2] = '{2, 1};
  int max_k[2] = '{4, 1};
  bit pend[2];
  bit own_d[2];
  bit own_we[2];
  int resp_at[2];
  int streak[2];
  int cyc = 0;

  task automatic model_step(input int k, output logic [135:0] e);
    bit r, win, wd, wi, mwe;
    logic [1:0]  msz;
    logic [31:0] maddr, mwd, ird, drd;
    r   = !rst && pend[k] && (cyc == resp_at[k]);
    win = !rst && (!pend[k] || r);
    wd  = win && d_req && !(if_req && streak[k] == max_k[k]);
    wi  = win && if_req && !wd;
    mwe = wd && d_we;
    msz = wd ? d_size : (wi ? 2'b10 : 2'b00);
    maddr = wd ? d_addr : (wi ? if_addr : 32'h0);
    mwd = wd ? d_wdata : 32'h0;
    ird = (r && !own_d[k]) ? m_rdata : 32'h0;
    drd = (r && own_d[k] && !own_we[k]) ? m_rdata : 32'h0;
    e = pk(wi, wd, r && !own_d[k], r && own_d[k], wd || wi, mwe, msz, maddr, mwd, ird, drd);
    if (rst) begin
      pend[k] = 1'b0;
      streak[k] = 0;
    end else begin
      if (wd || wi) begin
        pend[k] = 1'b1;
        resp_at[k] = cyc + lat_k[k];
        own_d[k] = wd;
        own_we[k] = wd && d_we;
      end else if (r) begin
        pend[k] = 1'b0;
      end
      if (!if_req || wi) streak[k] = 0;
      else if (wd) streak[k] = (streak[k] + 1 > max_k[k]) ? max_k[k] : streak[k] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] dg_seen, ig_seen, dv_seen, iv_seen;
    logic [135:0] e;
    bit ev;

    //   rst ir ia       dr we sz  da       dwd    mrd          ig dg iv dv en we sz  maddr    mwd    ird          drd
    row(1, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(1, 1, 32'h10,  0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 1, 32'h10,  0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       1, 0, 0, 0, 1, 0, 2'd2, 32'h10,  32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h00500093, 0, 0, 1, 0, 0, 0, 2'd0, 32'h0,  32'h0, 32'h00500093, 32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,  32'h0, 32'h0,       32'h0);
    row(0, 1, 32'h14,  1, 0, 2'd2, 32'h80,  32'h0, 32'h0,       0, 1, 0, 0, 1, 0, 2'd2, 32'h80,  32'h0, 32'h0,       32'h0);
    row(0, 1, 32'h14,  0, 0, 2'd0, 32'h0,   32'h0, 32'h12345678, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,  32'h0, 32'h0,       32'h0);
    row(0, 1, 32'h14,  0, 0, 2'd0, 32'h0,   32'h0, 32'h11112222, 1, 0, 0, 1, 1, 0, 2'd2, 32'h14, 32'h0, 32'h0,       32'h11112222);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h33334444, 0, 0, 1, 0, 0, 0, 2'd0, 32'h0,  32'h0, 32'h33334444, 32'h0);
    row(0, 0, 32'h0,   1, 1, 2'd0, 32'h41,  32'hAB, 32'h0,      0, 1, 0, 0, 1, 1, 2'd0, 32'h41,  32'hAB, 32'h0,      32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h55555555, 0, 0, 0, 1, 0, 0, 2'd0, 32'h0,  32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   1, 0, 2'd3, 32'h100, 32'h0, 32'h0,       0, 1, 0, 0, 1, 0, 2'd3, 32'h100, 32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h1,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h77,      0, 0, 0, 1, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h77);
    row(0, 1, 32'h200, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       1, 0, 0, 0, 1, 0, 2'd2, 32'h200, 32'h0, 32'h0,       32'h0);
    row(1, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 1, 32'h300, 0, 0, 2'd0, 32'h0,   32'h0, 32'h99,      1, 0, 0, 0, 1, 0, 2'd2, 32'h300, 32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       0, 0, 0, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'h0,       32'h0);
    row(0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   32'h0, 32'hAA,      0, 0, 1, 0, 0, 0, 2'd0, 32'h0,   32'h0, 32'hAA,      32'h0);

    tick();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; if_req = vecs[i].ir; if_addr = vecs[i].ia;
      d_req = vecs[i].dr; d_we = vecs[i].dwe; d_size = vecs[i].dsz;
      d_addr = vecs[i].da; d_wdata = vecs[i].dwd; m_rdata = vecs[i].mrd;
      #1;
      chk($sformatf("vec%0d", i), outs(0), vecs[i].exp);
      tick();
    end

    // Starvation guard on u0: both requesters held high.
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0;
    d_size = 2'b10; d_addr = 32'h800; d_wdata = '0;
    for (int c = 0; c < 12; c++) begin
      m_rdata = $urandom;
      #1;
      dg_seen[c] = d_gnt[0]; ig_seen[c] = if_gnt[0];
      dv_seen[c] = d_rvalid[0]; iv_seen[c] = if_rvalid[0];
      if (c == 9) chk("starve_dstreak_clear", 136'(u0.dstreak), 136'(0));
      tick();
    end
    chk("starve_d_gnt", 136'(dg_seen), 136'(12'h455));
    chk("starve_if_gnt", 136'(ig_seen), 136'(12'h100));
    chk("starve_d_rvalid", 136'(dv_seen), 136'(12'h154));
    chk("starve_if_rvalid", 136'(iv_seen), 136'(12'h400));

    // LAT=1 on u1: alternate data and fetch requests every cycle.
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    for (int c = 0; c < 10; c++) begin
      ev = (c % 2 == 0);
      d_req = ev; if_req = !ev; d_addr = 32'h900 + c; if_addr = 32'h500 + 4 * c;
      m_rdata = 32'hC0DE0000 + c;
      #1;
      chk($sformatf("alt_gnt%0d", c), 136'({if_gnt[1], d_gnt[1]}), 136'({!ev, ev}));
      chk($sformatf("alt_rvalid%0d", c), 136'({if_rvalid[1], d_rvalid[1]}),
          136'((c == 0) ? 2'b00 : {ev, !ev}));
      if (c > 0)
        chk($sformatf("alt_rdata%0d", c), 136'({if_rdata[1], d_rdata[1]}),
            ev ? 136'({32'hC0DE0000 + c, 32'h0}) : 136'({32'h0, 32'hC0DE0000 + c}));
      tick();
    end

    // Random stimulus against the reference model, both instances.
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom_range(0, 39) == 0);
      if_req = 1'($urandom_range(0, 1));
      if_addr = $urandom & 32'hFFFF_FFFC;
      d_req = 1'($urandom_range(0, 1));
      d_we = 1'($urandom_range(0, 1));
      d_size = 2'($urandom_range(0, 3));
      d_addr = $urandom;
      d_wdata = $urandom;
      m_rdata = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        model_step(k, e);
        chk($sformatf("rand_u%0d_c%0d", k, i), outs(k), e);
      end
      cyc++;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-ported data/instruction memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the RISC-V core. One transaction is outstanding at a time, and the memory has a fixed read latency. Data-side accesses have priority, and a streak limiter prevents fetch starvation. The block sits between imem/mem-stage requesters and the unified memory macro.

Parameters:
LAT, 2, memory latency in cycles from m_en to valid m_rdata (legal range 1..15)
MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending before fetch is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  32  fetch address (word aligned)
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request; held with d_we/d_size/d_addr/d_wdata stable until d_gnt
d_we  in  1  1=store, 0=load
d_size  in  2  00 byte, 01 half, 10 word
d_addr  in  32  data address
d_wdata  in  32  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid or store completed
d_rdata  out  32  load data (0 for stores)
m_en  out  1  memory access strobe
m_we  out  1  memory write enable
m_size  out  2  access size to memory
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, valid LAT cycles after m_en

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on ports clk and rst.
- State: busy flag, owner bit (0 fetch, 1 data), owner_we, latency counter cnt, streak counter dstreak.
- Arbitration window: the cycle when busy=0, or the cycle when cnt reaches the response point (the response and the next grant coincide).
- In an arbitration window with a request pending, exactly one gnt is asserted combinationally in that cycle.
  - m_en=1 in the same cycle; m_addr/m_we/m_size/m_wdata are muxed from the winner.
  - For a fetch, m_we=0 and m_size=10.
- Priority:
  - Data wins if d_req, unless dstreak==MAX_DSTREAK and if_req=1, in which case fetch wins.
  - Fetch wins if only if_req is asserted.
- dstreak:
  - Increments (saturating at MAX_DSTREAK) on each data grant while if_req=1.
  - Clears on any fetch grant, or in any cycle with if_req=0.
- Grant at cycle t: owner and owner_we are latched, busy=1, cnt=LAT.
  - cnt decrements each cycle.
  - At t+LAT, the owner's rvalid pulses for one cycle.
  - rdata = m_rdata for a read; d_rdata = 0 for a store.
  - busy clears unless a new grant occurs in the same cycle.
- Throughput: at most one grant per LAT cycles. Back-to-back requests produce rvalid and the new grant in the same cycle.
- No gnt, m_en, or rvalid is asserted while busy outside the response cycle.
- A requester deasserting req before gnt is legal: the request is dropped and nothing is issued. Changing the address while req is held and not yet granted is illegal.
- Loads and stores are not reordered; there is never more than one outstanding transaction.
- Reset:
  - All outputs are 0 during and after rst until a new grant. rdata outputs are 0.
  - busy=0, cnt=0, dstreak=0, owner=0.
  - Reset mid-transaction discards the outstanding response: no rvalid is issued for it after rst is released.
- Unused size encoding 11 is passed through unchanged; the memory defines its behaviour.
- if_rdata and d_rdata are driven only during their rvalid cycle and are 0 otherwise.

Test Plan:
- Fetch only, LAT=2:
  - if_req with if_addr=0x10 at cycle 5 -> if_gnt and m_en at 5, m_addr=0x10, m_we=0, m_size=10.
  - if_rvalid at 7 with if_rdata = m_rdata (0x00500093).
- Simultaneous requests at cycle 0: d_req load 0x80, if_req 0x14 ->
  - d_gnt at 0, d_rvalid at 2.
  - if_gnt at 2 (same cycle as d_rvalid), if_rvalid at 4.
- Starvation guard, MAX_DSTREAK=4: d_req held high continuously, if_req high ->
  - Four consecutive d_gnt.
  - 5th grant goes to fetch, dstreak reads 0 afterwards, and data resumes on the next window.
- Store d_we=1, d_size=00, d_addr=0x41, d_wdata=0xAB ->
  - m_we=1, m_size=00, m_wdata=0xAB at grant.
  - d_rvalid=1 with d_rdata=0 at grant+LAT; if_rvalid stays 0.
- Reset mid-operation: rst asserted the cycle after a fetch grant, deasserted one cycle later ->
  - No if_rvalid.
  - All outputs 0.
  - A new if_req is granted in the first cycle after rst is released.
- LAT=1, alternating d_req/if_req every cycle -> one grant per cycle, with each rvalid exactly one cycle after its grant.
